// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable registered or FWFT read.
module sync_fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  // Handshake: a write is taken when wr_en=1 and full=0; a read/pop is taken
  // when rd_en=1 and empty=0. Both decisions use only registered state, so a
  // write at full is dropped even if a read is accepted in the same cycle.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  overflow_q;
  logic                  underflow_q;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately not reset; stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full)  overflow_q <= 1'b1;
      else if (clr_err)   overflow_q <= 1'b0;
      if (rd_en && empty) underflow_q <= 1'b1;
      else if (clr_err)   underflow_q <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: registered-read instance checked through a
// scoreboard queue, plus a small directed FWFT instance.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Registered-read instance (FWFT=0)
  logic       f0_wr_en = 1'b0, f0_rd_en = 1'b0, f0_clr_err = 1'b0;
  logic [7:0] f0_wr_data = '0;
  logic [7:0] f0_rd_data;
  logic       f0_full, f0_afull, f0_empty, f0_aempty, f0_rd_valid, f0_ovf, f0_udf;
  logic [4:0] f0_count;

  // First-word-fall-through instance (FWFT=1)
  logic       f1_wr_en = 1'b0, f1_rd_en = 1'b0, f1_clr_err = 1'b0;
  logic [7:0] f1_wr_data = '0;
  logic [7:0] f1_rd_data;
  logic       f1_full, f1_afull, f1_empty, f1_aempty, f1_rd_valid, f1_ovf, f1_udf;
  logic [4:0] f1_count;

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(f0_wr_en), .wr_data(f0_wr_data),
    .full(f0_full), .almost_full(f0_afull), .rd_en(f0_rd_en),
    .rd_data(f0_rd_data), .rd_valid(f0_rd_valid), .empty(f0_empty),
    .almost_empty(f0_aempty), .count(f0_count), .overflow(f0_ovf),
    .underflow(f0_udf), .clr_err(f0_clr_err)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(f1_wr_en), .wr_data(f1_wr_data),
    .full(f1_full), .almost_full(f1_afull), .rd_en(f1_rd_en),
    .rd_data(f1_rd_data), .rd_valid(f1_rd_valid), .empty(f1_empty),
    .almost_empty(f1_aempty), .count(f1_count), .overflow(f1_ovf),
    .underflow(f1_udf), .clr_err(f1_clr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus on the registered instance; expected read data is
  // queued when the model says the read will be accepted.
  task automatic op(input logic we, input logic [7:0] d, input logic re, input logic ce);
    bit wacc, racc;
    f0_wr_en = we; f0_wr_data = d; f0_rd_en = re; f0_clr_err = ce;
    racc = re && (model_q.size() > 0);
    wacc = we && (model_q.size() < 16);
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(d);
    tick();
    f0_wr_en = 1'b0; f0_rd_en = 1'b0; f0_clr_err = 1'b0;
  endtask

  // Monitor: every rd_valid on the registered instance must match the queue head.
  always @(negedge clk) begin
    if (f0_rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data_unexpected: got 0x%0h with no expected word at %0t", f0_rd_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (f0_rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", f0_rd_data, e, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset / idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_empty",   32'(f0_empty), 1);
    chk("rst_aempty",  32'(f0_aempty), 1);
    chk("rst_full",    32'(f0_full), 0);
    chk("rst_afull",   32'(f0_afull), 0);
    chk("rst_count",   32'(f0_count), 0);
    chk("rst_rd_valid",32'(f0_rd_valid), 0);
    chk("rst_rd_data", 32'(f0_rd_data), 0);
    chk("rst_ovf",     32'(f0_ovf), 0);
    chk("rst_udf",     32'(f0_udf), 0);
    chk("rst_f1_valid",32'(f1_rd_valid), 0);

    // FWFT: a write into empty is visible the cycle after the write edge
    f1_wr_en = 1'b1; f1_wr_data = 8'h3C;
    tick();
    f1_wr_en = 1'b0;
    chk("fwft_valid_after_wr", 32'(f1_rd_valid), 1);
    chk("fwft_head_3c",        32'(f1_rd_data), 32'h3C);
    f1_rd_en = 1'b1;
    tick();
    f1_rd_en = 1'b0;
    chk("fwft_empty_after_pop", 32'(f1_empty), 1);
    chk("fwft_valid_after_pop", 32'(f1_rd_valid), 0);
    f1_wr_en = 1'b1; f1_wr_data = 8'h11; tick();
    f1_wr_data = 8'h22; tick();
    f1_wr_en = 1'b0;
    chk("fwft_head_11", 32'(f1_rd_data), 32'h11);
    chk("fwft_count_2", 32'(f1_count), 2);
    f1_rd_en = 1'b1; tick(); f1_rd_en = 1'b0;
    chk("fwft_head_22", 32'(f1_rd_data), 32'h22);
    chk("fwft_valid_22", 32'(f1_rd_valid), 1);

    // Fill to full with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(f0_count), 32'(i + 1));
      chk("fill_afull", 32'(f0_afull), 32'((i + 1) >= 14));
      chk("fill_full",  32'(f0_full),  32'((i + 1) == 16));
    end
    op(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("overflow_set",      32'(f0_ovf), 1);
    chk("overflow_count_16", 32'(f0_count), 16);

    // Drain; monitor checks 0x00..0x0F, one cycle after each rd_en
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_count", 32'(f0_count), 32'(15 - i));
    end
    chk("drain_empty", 32'(f0_empty), 1);
    tick();
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow_set",      32'(f0_udf), 1);
    chk("underflow_no_valid", 32'(f0_rd_valid), 0);

    // Clear sticky errors
    op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overflow",  32'(f0_ovf), 0);
    chk("clr_underflow", 32'(f0_udf), 0);

    // Simultaneous read/write at count 5 across the pointer wrap
    for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("rw_start_count", 32'(f0_count), 5);
    for (int i = 0; i < 20; i++) begin
      op(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      chk("rw_count_hold", 32'(f0_count), 5);
    end

    // Back to full, then set-wins-over-clear and write-dropped-at-full
    for (int i = 0; i < 11; i++) op(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("refill_full", 32'(f0_full), 1);
    op(1'b1, 8'hBB, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(f0_ovf), 1);
    chk("ovf_set_wins_count", 32'(f0_count), 16);
    op(1'b1, 8'hCC, 1'b1, 1'b0);
    chk("full_rw_count_15", 32'(f0_count), 15);
    chk("full_rw_not_full", 32'(f0_full), 0);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf_again", 32'(f0_ovf), 0);

    // Down to 7, then reset mid-operation
    for (int i = 0; i < 8; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count_7", 32'(f0_count), 7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    chk("mid_rst_count", 32'(f0_count), 0);
    chk("mid_rst_empty", 32'(f0_empty), 1);
    chk("mid_rst_valid", 32'(f0_rd_valid), 0);
    op(1'b1, 8'h55, 1'b0, 1'b0);
    chk("post_rst_count_1", 32'(f0_count), 1);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("post_rst_empty", 32'(f0_empty), 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock, parametrised FIFO and the same-domain successor of the dual-clock pointer-based FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A selectable read mode offers either registered-read or first-word-fall-through (FWFT). It is used for buffering inside a single clock domain and in UVM benches as a reference-able buffer stage.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16).
- FWFT, 0, read mode.
  - 0 = registered read, 1-cycle latency.
  - 1 = head word presented on rd_data whenever not empty.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this; legal 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this; legal 0..DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request (FWFT: pop request).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data qualifier.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: wr_en seen while full.
- underflow  out  1  sticky: rd_en seen while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr, rd_ptr, count = 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - rd_data=0, rd_valid=0 (registered mode), overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset mid-stream discards all stored words. First post-reset read of new data returns only data written after reset.
- Accept rules, evaluated on current registered state:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
  - A write while full is dropped even if rd_acc is true the same cycle, so full never depends on same-cycle rd_en.
  - Read while empty with simultaneous write: read dropped, write accepted.
- Pointers:
  - ADDR_WIDTH-bit binary pointers, wrap naturally from DEPTH-1 to 0.
  - wr_acc: mem[wr_ptr] <= wr_data, wr_ptr++.
  - rd_acc: rd_ptr++.
- Count update:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
  - Never exceeds DEPTH, never below 0.
- Flags: full, empty, almost_full, almost_empty are pure decodes of the count register, so they change in the cycle after the causing accept.
- Registered mode (FWFT=0):
  - On rd_acc: rd_data <= mem[rd_ptr], rd_valid <= 1 next cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr] combinationally.
  - rd_en pops the head, and the next word appears the cycle after.
  - A word written into an empty FIFO becomes visible (rd_valid=1) one cycle after the write edge.
  - rd_data content is don't-care while rd_valid=0.
- Error flags:
  - overflow <= 1 when wr_en & full.
  - underflow <= 1 when rd_en & empty.
  - Flags stay set until clr_err=1 or rst.
  - When clr_err is high in the same cycle as a new error, set wins.
- Threshold parameters outside their legal ranges are a compile-time error (elaboration assertion).

Test Plan:
- Reset/idle: assert rst 2 cycles → empty=1, almost_empty=1, full=0, count=0, rd_valid=0, overflow=underflow=0.
- Fill to full (defaults): 16 writes of 0x00..0x0F → count steps 1..16; almost_full first seen with count=14; full=1 with count=16. A 17th write of 0xAA is dropped, overflow=1, count stays 16.
- Drain (FWFT=0): 16 reads after fill → rd_data 0x00..0x0F, each one cycle after its rd_en; empty=1 at count=0. One more rd_en → underflow=1 and rd_valid stays 0.
- Simultaneous read/write at count=5 for 20 cycles → count holds at 5, data order is preserved across the pointer wrap. At full with rd_en=wr_en=1 → write dropped, count 16→15.
- FWFT=1: write 0x3C into empty FIFO → rd_valid=1 and rd_data=0x3C the next cycle. rd_en pop → empty=1 next cycle.
- Error clear and reset mid-operation: with overflow=1, pulse clr_err → overflow=0 next cycle. With count=7, assert rst → count=0, empty=1. Then write 0x55 and read it back → 0x55.
